// File: rtl/escalonador.sv
// Round-robin scheduler for one shared resource among four requesters.
// A granted requester holds the resource for DURACAO time units (Tick strobes)
// or until it cancels; a one-cycle release state separates consecutive grants.
module escalonador #(
  parameter logic [6:0] DURACAO = 7'd6
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick,
  input  logic [3:0] Pedido,
  input  logic       Cancelar,
  output logic [3:0] Concessao,
  output logic [1:0] Dono,
  output logic       Ocupado,
  output logic [6:0] Tempo,
  output logic [6:0] Termino,
  output logic       Fim
);

  typedef enum logic [1:0] {StLivre, StOcupado, StLiberta} state_e;

  state_e     state_q, state_d;
  logic [6:0] tempo_q, tempo_d;
  logic [6:0] termino_q, termino_d;
  logic [1:0] dono_q, dono_d;
  logic [1:0] ultimo_q, ultimo_d;
  logic [3:0] concessao_q, concessao_d;
  logic       ocupado_q, ocupado_d;
  logic       fim_q, fim_d;

  logic       sel_valid;
  logic [1:0] sel_idx;
  logic [1:0] rr_cand;

  // Round-robin pick: search upward starting just after the last owner.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = ultimo_q;
    rr_cand   = ultimo_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      rr_cand = ultimo_q + 2'(i);
      if (!sel_valid && Pedido[rr_cand]) begin
        sel_valid = 1'b1;
        sel_idx   = rr_cand;
      end
    end
  end

  // Next-state logic; grant and end-of-reservation strobes default low.
  always_comb begin
    state_d     = state_q;
    tempo_d     = Tick ? tempo_q + 7'd1 : tempo_q;
    termino_d   = termino_q;
    dono_d      = dono_q;
    ultimo_d    = ultimo_q;
    concessao_d = 4'b0000;
    ocupado_d   = ocupado_q;
    fim_d       = 1'b0;
    case (state_q)
      StLivre: begin
        if (sel_valid) begin
          concessao_d = 4'b0001 << sel_idx;
          dono_d      = sel_idx;
          ultimo_d    = sel_idx;
          ocupado_d   = 1'b1;
          // Uses the pre-increment time even when Tick coincides.
          termino_d   = tempo_q + DURACAO;
          state_d     = StOcupado;
        end
      end
      StOcupado: begin
        // Equality on 7-bit values handles wrap of the end time past 127.
        if ((tempo_q == termino_q) || Cancelar) begin
          fim_d     = 1'b1;
          ocupado_d = 1'b0;
          state_d   = StLiberta;
        end
      end
      StLiberta: begin
        state_d = StLivre;
      end
      default: begin
        state_d = StLivre;
      end
    endcase
  end

  // State registers with synchronous active-low reset; Ultimo=3 favours requester 0.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= StLivre;
      tempo_q     <= 7'd0;
      termino_q   <= 7'd0;
      dono_q      <= 2'd0;
      ultimo_q    <= 2'd3;
      concessao_q <= 4'b0000;
      ocupado_q   <= 1'b0;
      fim_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tempo_q     <= tempo_d;
      termino_q   <= termino_d;
      dono_q      <= dono_d;
      ultimo_q    <= ultimo_d;
      concessao_q <= concessao_d;
      ocupado_q   <= ocupado_d;
      fim_q       <= fim_d;
    end
  end

  assign Concessao = concessao_q;
  assign Dono      = dono_q;
  assign Ocupado   = ocupado_q;
  assign Tempo     = tempo_q;
  assign Termino   = termino_q;
  assign Fim       = fim_q;

endmodule

// File: tb/tb_escalonador.sv
// Scoreboard bench for escalonador: stimulus pushes expected grant/end events,
// a negedge monitor pops and compares whenever Concessao or Fim is active.
module tb_escalonador;

  localparam logic [6:0] D = 7'd6;

  logic       Clk;
  logic       Rst_n;
  logic       Tick;
  logic [3:0] Pedido;
  logic       Cancelar;
  logic [3:0] Concessao;
  logic [1:0] Dono;
  logic       Ocupado;
  logic [6:0] Tempo;
  logic [6:0] Termino;
  logic       Fim;

  escalonador #(.DURACAO(D)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Tick      (Tick),
    .Pedido    (Pedido),
    .Cancelar  (Cancelar),
    .Concessao (Concessao),
    .Dono      (Dono),
    .Ocupado   (Ocupado),
    .Tempo     (Tempo),
    .Termino   (Termino),
    .Fim       (Fim)
  );

  typedef struct packed {
    logic [3:0] conc;
    logic [1:0] dono;
    logic       ocup;
    logic       fim;
    logic [6:0] term;
    logic [6:0] tempo;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [6:0] tm;  // model of Tempo

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock edge; inputs were set beforehand, outputs settle #1 after the edge.
  task automatic cyc(input logic tk);
    Tick = tk;
    @(posedge Clk);
    #1;
    if (!Rst_n) tm = 7'd0;
    else if (tk) tm = tm + 7'd1;
    Tick = 1'b0;
  endtask

  // Call before the granting edge; termino uses the pre-edge time.
  task automatic push_grant(input int idx, input logic [6:0] tempo_after);
    ev_t e;
    e.conc  = 4'b0001 << idx;
    e.dono  = 2'(idx);
    e.ocup  = 1'b1;
    e.fim   = 1'b0;
    e.term  = tm + D;
    e.tempo = tempo_after;
    exp_q.push_back(e);
  endtask

  task automatic push_fim(input int dono, input logic [6:0] term, input logic [6:0] tempo);
    ev_t e;
    e.conc  = 4'b0000;
    e.dono  = 2'(dono);
    e.ocup  = 1'b0;
    e.fim   = 1'b1;
    e.term  = term;
    e.tempo = tempo;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    Rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " Tempo"},     int'(Tempo),     0);
    chk({tag, " Termino"},   int'(Termino),   0);
    chk({tag, " Dono"},      int'(Dono),      0);
    chk({tag, " Concessao"}, int'(Concessao), 0);
    chk({tag, " Ocupado"},   int'(Ocupado),   0);
    chk({tag, " Fim"},       int'(Fim),       0);
  endtask

  // Monitor: every cycle with an active grant or Fim must match the next expected event.
  always @(negedge Clk) begin
    if (Concessao != 4'b0000 || Fim) begin
      ev_t act, req;
      act = '{conc: Concessao, dono: Dono, ocup: Ocupado, fim: Fim, term: Termino, tempo: Tempo};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_event: actual conc=%b dono=%0d ocup=%b fim=%b term=%0d tempo=%0d required=none",
                 act.conc, act.dono, act.ocup, act.fim, act.term, act.tempo);
      end else begin
        req = exp_q.pop_front();
        if (act != req) begin
          n_fails++;
          $display("FAIL event: actual conc=%b dono=%0d ocup=%b fim=%b term=%0d tempo=%0d required conc=%b dono=%0d ocup=%b fim=%b term=%0d tempo=%0d",
                   act.conc, act.dono, act.ocup, act.fim, act.term, act.tempo,
                   req.conc, req.dono, req.ocup, req.fim, req.term, req.tempo);
        end
      end
    end
  end

  initial begin
    Rst_n = 1'b0; Tick = 1'b0; Pedido = 4'b0000; Cancelar = 1'b0; tm = 7'd0;

    // Scenario 1: single grant, natural expiry after 6 ticks.
    do_reset();
    chk_reset_vals("s1 reset");
    Pedido = 4'b0001;
    push_grant(0, 7'd0);
    cyc(1'b0);
    Pedido = 4'b0000;
    for (int i = 0; i < 6; i++) cyc(1'b1);
    chk("s1 Ocupado before expiry", int'(Ocupado), 1);
    push_fim(0, 7'd6, 7'd6);
    cyc(1'b0);
    cyc(1'b0);
    chk("s1 Fim after LIBERTA", int'(Fim), 0);
    chk("s1 Termino held", int'(Termino), 6);

    // Scenario 2: all requesting, order 0,1,2,3,0; no grant issued in LIBERTA.
    do_reset();
    Pedido = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      push_grant(r % 4, 7'd0);
      cyc(1'b0);
      Pedido[r % 4] = 1'b0;
      cyc(1'b0);
      Cancelar = 1'b1;
      push_fim(r % 4, 7'd6, 7'd0);
      cyc(1'b0);
      Cancelar = 1'b0;
      Pedido = 4'b1111;
      cyc(1'b0);
    end
    Pedido = 4'b0000;
    cyc(1'b0);

    // Scenario 3: grant at Tempo=125, end time wraps to 3.
    do_reset();
    for (int i = 0; i < 125; i++) cyc(1'b1);
    chk("s3 Tempo before grant", int'(Tempo), 125);
    Pedido = 4'b0010;
    push_grant(1, 7'd125);
    cyc(1'b0);
    Pedido = 4'b0000;
    for (int i = 0; i < 6; i++) cyc(1'b1);
    chk("s3 Ocupado at Tempo 3", int'(Ocupado), 1);
    push_fim(1, 7'd3, 7'd3);
    cyc(1'b0);
    cyc(1'b0);

    // Scenario 4: early cancel, pending request granted through LIBERTA, cancel in LIVRE ignored.
    do_reset();
    cyc(1'b1);
    Pedido = 4'b0001;
    push_grant(0, 7'd1);
    cyc(1'b0);
    Pedido = 4'b0100;
    cyc(1'b0);
    Cancelar = 1'b1;
    push_fim(0, 7'd7, 7'd1);
    cyc(1'b0);
    Cancelar = 1'b0;
    cyc(1'b0);
    chk("s4 no grant in LIBERTA", int'(Concessao), 0);
    push_grant(2, 7'd1);
    cyc(1'b0);
    Pedido = 4'b0000;
    Cancelar = 1'b1;
    push_fim(2, 7'd7, 7'd1);
    cyc(1'b0);
    Cancelar = 1'b0;
    cyc(1'b0);
    Cancelar = 1'b1;
    cyc(1'b0);
    Cancelar = 1'b0;
    chk("s4 Fim on LIVRE cancel", int'(Fim), 0);
    cyc(1'b0);
    chk("s4 Ocupado after LIVRE cancel", int'(Ocupado), 0);

    // Scenario 5: Tick with grant at Tempo=10, cancel coincident with expiry.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1);
    Pedido = 4'b0001;
    push_grant(0, 7'd11);
    cyc(1'b1);
    Pedido = 4'b0000;
    for (int i = 0; i < 5; i++) cyc(1'b1);
    Cancelar = 1'b1;
    push_fim(0, 7'd16, 7'd16);
    cyc(1'b0);
    Cancelar = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("s5 Fim after single pulse", int'(Fim), 0);

    // Scenario 6: reset mid-reservation, then fresh grant from LIVRE.
    do_reset();
    Pedido = 4'b0010;
    push_grant(1, 7'd0);
    cyc(1'b0);
    Pedido = 4'b0000;
    cyc(1'b1);
    cyc(1'b1);
    Rst_n = 1'b0;
    Cancelar = 1'b1;
    cyc(1'b1);
    Rst_n = 1'b1;
    Cancelar = 1'b0;
    chk_reset_vals("s6 mid reset");
    Pedido = 4'b1000;
    push_grant(3, 7'd0);
    cyc(1'b0);
    Pedido = 4'b0000;
    cyc(1'b0);
    cyc(1'b0);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
